// File: rtl/hnm_row_readback_pkg.sv
// Shared widths, types and state encoding for the HNM row readback block.
// Imported by the interface, the encoder and the top.
package hnm_row_readback_pkg;

  localparam int ROWINDEXBITS_HNM = 4;
  localparam int COLINDEXBITS_HNM = 4;
  localparam int NCOLS_HNM = 1 << COLINDEXBITS_HNM;
  localparam int NROWS_HNM = 16;
  localparam int SSIDBITS  = ROWINDEXBITS_HNM + COLINDEXBITS_HNM;
  localparam int NSSID_MAX = NROWS_HNM * NCOLS_HNM;

  typedef logic [ROWINDEXBITS_HNM-1:0] row_t;
  typedef logic [COLINDEXBITS_HNM-1:0] col_t;
  typedef logic [NCOLS_HNM-1:0]        bitmap_t;
  typedef logic [SSIDBITS-1:0]         ssid_t;
  typedef logic [SSIDBITS:0]           cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/hnm_row_readback_if.sv
// Bundle of the HNM row-read port and the SSID output stream.
// master = reader (issues row reads, sources SSIDs); slave = HNM + sink.
interface hnm_row_readback_if;
  import hnm_row_readback_pkg::*;

  logic    readReady;
  logic    readRow;
  row_t    rowRead;
  logic    rowRespValid;
  row_t    rowPassed;
  bitmap_t rowReadOutput;
  logic    ssidValid;
  logic    ssidReady;
  ssid_t   ssidOut;

  modport master (
    input  readReady,
    output readRow,
    output rowRead,
    input  rowRespValid,
    input  rowPassed,
    input  rowReadOutput,
    output ssidValid,
    input  ssidReady,
    output ssidOut
  );

  modport slave (
    output readReady,
    input  readRow,
    input  rowRead,
    output rowRespValid,
    output rowPassed,
    output rowReadOutput,
    input  ssidValid,
    output ssidReady,
    input  ssidOut
  );

endinterface

// File: rtl/hnm_row_readback_lsb_enc.sv
// Combinational lowest-set-bit encoder: vec_i bitmap in,
// idx_o = index of lowest set bit, any_o = vec_i has a set bit.
module lowest_set_bit_encoder
  import hnm_row_readback_pkg::*;
(
  input  bitmap_t vec_i,
  output col_t    idx_o,
  output logic    any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // Scan high to low so the lowest set bit is the last to win.
    for (int i = NCOLS_HNM - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = col_t'(i);
    end
  end

endmodule

// File: rtl/hnm_row_readback.sv
// Scans all HNM rows on start and streams each set bit as SSID {row,col}.
// Ports: clk, reset (async high), start, bus (master), busy, done, nSSIDs, protocolError.
module hnm_row_readback
  import hnm_row_readback_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  hnm_row_readback_if.master bus,
  output logic busy,
  output logic done,
  output cnt_t nSSIDs,
  output logic protocolError
);

  state_t  state_q, state_d;
  row_t    row_q, row_d;
  bitmap_t mask_q, mask_d;
  cnt_t    cnt_q, cnt_d;
  logic    err_q, err_d;

  col_t    lsb_idx;
  logic    lsb_any;
  bitmap_t bit_oh;
  bitmap_t mask_clr;

  lowest_set_bit_encoder u_enc (
    .vec_i (mask_q),
    .idx_o (lsb_idx),
    .any_o (lsb_any)
  );

  assign bit_oh   = bitmap_t'(1) << lsb_idx;
  assign mask_clr = mask_q & ~bit_oh;

  assign bus.rowRead   = row_q;
  assign bus.ssidOut   = {row_q, lsb_idx};
  assign nSSIDs        = cnt_q;
  assign protocolError = err_q;

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    bus.readRow   = 1'b0;
    bus.ssidValid = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          row_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (bus.readReady) begin
          bus.readRow = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (bus.rowRespValid) begin
          // A mis-tagged response is dropped; keep waiting for ours.
          if (bus.rowPassed != row_q) begin
            err_d = 1'b1;
          end else begin
            mask_d  = bus.rowReadOutput;
            state_d = (|bus.rowReadOutput) ? S_DRAIN : S_NEXT;
          end
        end
      end
      S_DRAIN: begin
        busy          = 1'b1;
        bus.ssidValid = lsb_any;
        if (!lsb_any) begin
          state_d = S_NEXT;
        end else if (bus.ssidReady) begin
          mask_d = mask_clr;
          if (cnt_q != cnt_t'(NSSID_MAX)) cnt_d = cnt_q + 1'b1;
          if (mask_clr == '0) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        busy = 1'b1;
        if (row_q == row_t'(NROWS_HNM - 1)) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_hnm_row_readback.sv
// Directed bench for hnm_row_readback with a 2-cycle-latency HNM model.
// Checks row order, SSID stream, stalls, tag errors and mid-scan reset.
module tb_hnm_row_readback;
  import hnm_row_readback_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, protocolError;
  cnt_t nSSIDs;

  hnm_row_readback_if u_if ();

  hnm_row_readback dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .bus           (u_if),
    .busy          (busy),
    .done          (done),
    .nSSIDs        (nSSIDs),
    .protocolError (protocolError)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  bitmap_t mem [NROWS_HNM];
  ssid_t   ssid_q [$];
  int      rows_q [$];
  int      ndone = 0;
  int      pend_cnt;
  row_t    pend_row;
  logic    bad_en = 1'b0;
  row_t    bad_row = '0;

  ssid_t exp2 [17] = '{8'h2B, 8'h35, 8'h36, 8'h41, 8'h42, 8'h44,
                       8'h46, 8'h47, 8'h48, 8'h4C, 8'h80, 8'h85,
                       8'h87, 8'h88, 8'h8B, 8'h97, 8'hC7};
  ssid_t exp3 [7]  = '{8'h41, 8'h42, 8'h44, 8'h46, 8'h47, 8'h48, 8'h4C};
  ssid_t exp4 [3]  = '{8'h40, 8'h44, 8'h7F};
  ssid_t exp6 [5]  = '{8'h80, 8'h85, 8'h87, 8'h88, 8'h8B};

  // Monitor + HNM model, all on the falling edge.
  initial begin
    u_if.rowRespValid  = 1'b0;
    u_if.rowPassed     = '0;
    u_if.rowReadOutput = '0;
    pend_cnt = 0;
    pend_row = '0;
    forever begin
      @(negedge clk);
      if (u_if.ssidValid && u_if.ssidReady) ssid_q.push_back(u_if.ssidOut);
      if (u_if.readRow) rows_q.push_back(int'(u_if.rowRead));
      if (done) ndone++;
      u_if.rowRespValid = 1'b0;
      if (reset) begin
        pend_cnt = 0;
      end else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          u_if.rowRespValid  = 1'b1;
          u_if.rowReadOutput = mem[pend_row];
          if (bad_en && pend_row == bad_row) begin
            u_if.rowPassed = pend_row + 1'b1;
            bad_en   = 1'b0;
            pend_cnt = 1;
          end else begin
            u_if.rowPassed = pend_row;
          end
        end
      end
      if (!reset && u_if.readRow) begin
        pend_row = u_if.rowRead;
        pend_cnt = 2;
      end
    end
  end

  task automatic clear_mem();
    foreach (mem[r]) mem[r] = '0;
  endtask

  task automatic clear_q();
    ssid_q.delete();
    rows_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0;
    int i;
    n0 = ndone;
    for (i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ndone != n0) break;
    end
    chk(tag, 32'(i < budget), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (u_if.ssidValid) break;
    end
    chk(tag, 32'(i < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int i;
    logic [3:0] pat;
    pat = 4'b1001;
    u_if.readReady = 1'b1;
    u_if.ssidReady = 1'b1;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", u_if.ssidValid, 0);
    chk("rst_readrow", u_if.readRow, 0);
    chk("rst_nssids", nSSIDs, 0);
    chk("rst_err", protocolError, 0);
    chk("rst_ssidout", u_if.ssidOut, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Empty HNM: 16 row reads, nothing emitted.
    clear_q();
    pulse_start();
    chk("t1_busy_next", busy, 1);
    chk("t1_first_readrow", u_if.readRow, 1);
    wait_done("t1_done", 300);
    chk("t1_nrows", rows_q.size(), 16);
    bad = 0;
    foreach (rows_q[k]) if (rows_q[k] != k) bad++;
    chk("t1_row_order", bad, 0);
    chk("t1_nssid_q", ssid_q.size(), 0);
    chk("t1_nssids", nSSIDs, 0);
    chk("t1_busy_done", busy, 0);

    // Full pattern.
    mem[2]  = 16'h0800;
    mem[3]  = 16'h0060;
    mem[4]  = 16'h11D6;
    mem[8]  = 16'h09A1;
    mem[9]  = 16'h0080;
    mem[12] = 16'h0080;
    clear_q();
    pulse_start();
    wait_done("t2_done", 500);
    chk("t2_count", ssid_q.size(), 17);
    for (int k = 0; k < 17; k++)
      if (k < ssid_q.size()) chk($sformatf("t2_ssid%0d", k), ssid_q[k], exp2[k]);
    chk("t2_nssids", nSSIDs, 17);
    chk("t2_err", protocolError, 0);

    // Backpressure on row 4.
    clear_mem();
    mem[4] = 16'h11D6;
    u_if.ssidReady = 1'b0;
    clear_q();
    pulse_start();
    wait_valid("t3_valid_seen", 200);
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold", u_if.ssidOut, 8'h41);
      chk("t3_hold_valid", u_if.ssidValid, 1);
      @(negedge clk); #1;
    end
    bad = ndone;
    for (i = 0; i < 300; i++) begin
      @(posedge clk); #1 u_if.ssidReady = pat[i % 4];
      @(negedge clk); #1;
      if (ndone != bad) break;
    end
    chk("t3_done", 32'(i < 300), 1);
    chk("t3_count", ssid_q.size(), 7);
    for (int k = 0; k < 7; k++)
      if (k < ssid_q.size()) chk($sformatf("t3_ssid%0d", k), ssid_q[k], exp3[k]);
    chk("t3_nssids", nSSIDs, 7);
    u_if.ssidReady = 1'b1;

    // Wrong row tag on row 4.
    clear_mem();
    mem[4] = 16'h0011;
    mem[7] = 16'h8000;
    bad_en  = 1'b1;
    bad_row = 4'd4;
    clear_q();
    pulse_start();
    for (i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (protocolError) break;
    end
    chk("t4_err_set", 32'(i < 200), 1);
    wait_done("t4_done", 300);
    chk("t4_err_sticky", protocolError, 1);
    chk("t4_count", ssid_q.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < ssid_q.size()) chk($sformatf("t4_ssid%0d", k), ssid_q[k], exp4[k]);
    repeat (3) @(negedge clk);
    #1 chk("t4_err_idle", protocolError, 1);

    // readReady held low after start.
    clear_mem();
    u_if.readReady = 1'b0;
    clear_q();
    pulse_start();
    chk("t5_err_clr", protocolError, 0);
    repeat (10) @(negedge clk);
    #1;
    chk("t5_no_readrow", rows_q.size(), 0);
    chk("t5_busy", busy, 1);
    @(posedge clk); #1 u_if.readReady = 1'b1;
    #1;
    chk("t5_readrow", u_if.readRow, 1);
    chk("t5_row0", u_if.rowRead, 0);
    wait_done("t5_done", 300);
    chk("t5_nrows", rows_q.size(), 16);

    // Reset in the middle of draining row 8.
    mem[8] = 16'h09A1;
    u_if.ssidReady = 1'b0;
    clear_q();
    pulse_start();
    wait_valid("t6_valid_seen", 300);
    chk("t6_row8", u_if.ssidOut, 8'h80);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", u_if.ssidValid, 0);
    chk("t6_rst_done", done, 0);
    @(posedge clk); #1 reset = 1'b0;
    u_if.ssidReady = 1'b1;
    clear_q();
    pulse_start();
    wait_done("t6_done", 300);
    chk("t6_nrows", rows_q.size(), 16);
    if (rows_q.size() > 0) chk("t6_first_row", rows_q[0], 0);
    chk("t6_count", ssid_q.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < ssid_q.size()) chk($sformatf("t6_ssid%0d", k), ssid_q[k], exp6[k]);
    chk("t6_nssids", nSSIDs, 5);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/hnm_row_readback.md
Name: hnm_row_readback

Overview:
- Reader counterpart to the SSID write path into HNMPP.
- On a start pulse, scans every HNM row in ascending order using the row-read port.
- Priority-encodes each returned NCOLS_HNM-bit bitmap into individual SSIDs {row, col}.
- Streams the SSIDs out one per cycle over a valid/ready handshake. Used for end-of-event readback of stored SSIDs and for bench checking of the write path.

Parameters:
- ROWINDEXBITS_HNM, 4, row index width.
- COLINDEXBITS_HNM, 4, column index width.
- NCOLS_HNM, 16, bitmap width; must equal 2**COLINDEXBITS_HNM.
- NROWS_HNM, 16, rows scanned, 0..NROWS_HNM-1; must be <= 2**ROWINDEXBITS_HNM.
- SSIDBITS, 8, equals ROWINDEXBITS_HNM+COLINDEXBITS_HNM.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a scan.
- readReady  in  1  HNM can accept a row read.
- readRow  out  1  one-cycle row-read request to HNM.
- rowRead  out  ROWINDEXBITS_HNM  row being requested.
- rowRespValid  in  1  HNM row response valid.
- rowPassed  in  ROWINDEXBITS_HNM  row index tagged on the response.
- rowReadOutput  in  NCOLS_HNM  bitmap of the returned row.
- ssidValid  out  1  ssidOut valid.
- ssidReady  in  1  downstream accepts ssidOut.
- ssidOut  out  SSIDBITS  {row, col}.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the scan completes.
- nSSIDs  out  SSIDBITS+1  SSIDs emitted in the current/last scan.
- protocolError  out  1  sticky; set on a row-tag mismatch.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; rowCnt=0; bitmap register=0; nSSIDs=0; protocolError=0.
- IDLE:
  - start=1 -> ISSUE; clear rowCnt, nSSIDs, protocolError; busy=1 from the next cycle.
  - start while busy is ignored.
- ISSUE:
  - While readReady=0, hold; readRow stays 0.
  - When readReady=1, assert readRow=1 for exactly one cycle with rowRead=rowCnt, then -> WAIT.
  - Earliest readRow is the cycle after start.
- WAIT:
  - Hold until rowRespValid=1; there is no timeout.
  - If rowPassed != rowCnt: set protocolError, discard the response, stay in WAIT.
  - Otherwise latch rowReadOutput into mask.
  - mask==0 -> NEXT. Empty rows emit nothing and cost no DRAIN cycle.
  - mask!=0 -> DRAIN.
- DRAIN:
  - ssidValid=1; ssidOut={rowCnt, index of lowest set bit of mask}.
  - On ssidValid&&ssidReady: clear that bit and increment nSSIDs.
  - If the cleared bit was the last set bit -> NEXT; otherwise present the next SSID in the following cycle.
  - Throughput is 1 SSID/cycle with ssidReady held high.
  - ssidOut is stable while ssidValid&&!ssidReady.
- NEXT:
  - rowCnt==NROWS_HNM-1 -> DONE.
  - Otherwise rowCnt+1 -> ISSUE. No wrap: the scan ends at the last row.
- DONE: done=1 for one cycle, busy=0, -> IDLE. nSSIDs holds until the next start.
- Responses arriving in IDLE, ISSUE or DRAIN are ignored and set no error.
- Priority encoder: combinational, lowest index wins; col width is COLINDEXBITS_HNM.
- nSSIDs saturates at NROWS_HNM*NCOLS_HNM; it cannot overflow at its width.
- Reset mid-scan: immediate return to IDLE; any pending HNM response is dropped.

Decomposition:
- Shared package/header (MyParameters.vh): ROWINDEXBITS_HNM, COLINDEXBITS_HNM, NCOLS_HNM, NROWS_HNM, SSIDBITS; state encoding localparams IDLE/ISSUE/WAIT/DRAIN/NEXT/DONE.
- One sub-module: lowest_set_bit_encoder (NCOLS_HNM in; COLINDEXBITS_HNM index out; any-set flag out).

Test Plan:
- Empty HNM, readReady=1, response 2 cycles after each readRow, ssidReady=1, start -> 16 readRow pulses (rows 0..15), no ssidValid, done pulse, nSSIDs=0.
- Write SSIDs (2,11),(3,5),(3,6),(4,1),(4,2),(4,4),(4,6),(4,7),(4,8),(4,12),(8,0),(8,5),(8,7),(8,8),(8,11),(9,7),(12,7) into HNMPP, then start -> ssidOut sequence 0x2B,0x35,0x36,0x41,0x42,0x44,0x46,0x47,0x48,0x4C,0x80,0x85,0x87,0x88,0x8B,0x97,0xC7; nSSIDs=17.
- Row 4 bitmap 0x11D6 with ssidReady toggling 1,0,0,1 -> ssidOut holds 0x41 through the stall; each SSID is emitted once.
- Response with rowPassed=5 while rowCnt=4 -> protocolError=1 and sticky; the scan continues after the correct tag arrives.
- readReady=0 for 10 cycles after start -> no readRow during the stall; readRow asserts in the first cycle readReady=1.
- Assert reset during DRAIN of row 8 -> busy, ssidValid and done all 0 immediately; a new start rescans from row 0.
